// File: rtl/gmii_to_rgmii_tx.sv
// gmii_to_rgmii_tx: frames a valid/ready/last payload stream as an Ethernet
// frame on an internal GMII byte bus and drives the RGMII TX pins in DDR form.
//
// Ports:
//   TXCLK_i        125 MHz TX clock, both edges used
//   reset          synchronous active-low reset (posedge and negedge regs)
//   tx_data_i      payload byte
//   tx_valid_i     payload byte valid
//   tx_last_i      last payload byte of the frame
//   tx_ready_o     byte taken on posedge when tx_valid_i & tx_ready_o
//   RGMII_TXC_o    forwarded TX clock
//   RGMII_TXD_o    DDR data: G[3:0] high phase, G[7:4] low phase
//   RGMII_TXCTL_o  DDR control: EN high phase, EN^ER low phase
//   busy_o         FSM not idle
//   underrun_o     one-cycle pulse when the payload stream starves mid-frame
//   frame_cnt_o    frames completed with FCS, wrapping
module gmii_to_rgmii_tx #(
   parameter int PREAMBLE_LEN = 7,
   parameter int MIN_FRAME    = 60,
   parameter int IFG_BYTES    = 12
) (
   input  logic        TXCLK_i,
   input  logic        reset,
   input  logic [7:0]  tx_data_i,
   input  logic        tx_valid_i,
   input  logic        tx_last_i,
   output logic        tx_ready_o,
   output logic        RGMII_TXC_o,
   output logic [3:0]  RGMII_TXD_o,
   output logic        RGMII_TXCTL_o,
   output logic        busy_o,
   output logic        underrun_o,
   output logic [15:0] frame_cnt_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_SFD,
      S_DATA,
      S_PAD,
      S_FCS,
      S_DRAIN,
      S_IFG
   } state_t;

   localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN - 1);
   localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);
   localparam logic [16:0] MIN_LEN  = 17'(MIN_FRAME);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [7:0]  r_g;
   logic [7:0]  w_g_nxt;
   logic        r_en;
   logic        w_en_nxt;
   logic        r_er;
   logic        w_er_nxt;
   logic [15:0] r_cnt;
   logic [15:0] w_cnt_nxt;
   logic [15:0] w_cnt_inc;
   logic [31:0] r_crc;
   logic [31:0] w_crc_nxt;
   logic [7:0]  r_tick;
   logic [7:0]  w_tick_nxt;
   logic [15:0] r_frames;
   logic [15:0] w_frames_nxt;
   logic        r_underrun;
   logic        w_underrun_nxt;

   logic [3:0]  r_pos;
   logic        r_ctl_pos;
   logic [3:0]  r_hi_hold;
   logic        r_x_hold;
   logic [3:0]  r_neg;
   logic        r_ctl_neg;

   // Reflected CRC32 over one byte, LSB first.
   function automatic logic [31:0] crc_byte(
      input logic [31:0] c,
      input logic [7:0]  d
   );
      logic [31:0] v;
      v = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++) begin
         v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
      end
      return v;
   endfunction

   assign tx_ready_o  = (r_state == S_SFD) ||
                        (r_state == S_DATA) ||
                        (r_state == S_DRAIN);
   assign busy_o      = (r_state != S_IDLE);
   assign underrun_o  = r_underrun;
   assign frame_cnt_o = r_frames;
   assign RGMII_TXC_o = TXCLK_i;

   // G/EN/ER are loaded together with the state, so the byte chosen at a
   // posedge is on the GMII bus for the whole following cycle.
   always_comb begin
      w_state_nxt    = r_state;
      w_g_nxt        = 8'h00;
      w_en_nxt       = 1'b0;
      w_er_nxt       = 1'b0;
      w_cnt_nxt      = r_cnt;
      w_crc_nxt      = r_crc;
      w_frames_nxt   = r_frames;
      w_underrun_nxt = 1'b0;
      w_tick_nxt     = 8'd0;
      w_cnt_inc      = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

      unique case (r_state)
         S_IDLE: begin
            if (tx_valid_i) begin
               w_state_nxt = S_PRE;
               w_g_nxt     = 8'h55;
               w_en_nxt    = 1'b1;
            end
         end
         S_PRE: begin
            w_en_nxt = 1'b1;
            if (r_tick == PRE_LAST) begin
               w_state_nxt = S_SFD;
               w_g_nxt     = 8'hD5;
               w_cnt_nxt   = 16'd0;
               w_crc_nxt   = 32'hFFFF_FFFF;
            end else begin
               w_g_nxt = 8'h55;
            end
         end
         S_SFD,
         S_DATA: begin
            w_en_nxt = 1'b1;
            if (tx_valid_i) begin
               w_g_nxt   = tx_data_i;
               w_cnt_nxt = w_cnt_inc;
               w_crc_nxt = crc_byte(r_crc, tx_data_i);
               if (!tx_last_i) begin
                  w_state_nxt = S_DATA;
               end else if ({1'b0, w_cnt_inc} < MIN_LEN) begin
                  w_state_nxt = S_PAD;
               end else begin
                  w_state_nxt = S_FCS;
               end
            end else begin
               // A bubble once the payload has started cannot be hidden:
               // flag the frame with ER and throw away the rest of it.
               w_er_nxt       = 1'b1;
               w_underrun_nxt = 1'b1;
               w_state_nxt    = S_DRAIN;
            end
         end
         S_PAD: begin
            w_en_nxt  = 1'b1;
            w_cnt_nxt = w_cnt_inc;
            w_crc_nxt = crc_byte(r_crc, 8'h00);
            if ({1'b0, w_cnt_inc} >= MIN_LEN) begin
               w_state_nxt = S_FCS;
            end
         end
         S_FCS: begin
            w_en_nxt  = 1'b1;
            w_g_nxt   = ~r_crc[7:0];
            w_crc_nxt = {8'h00, r_crc[31:8]};
            if (r_tick == 8'd3) begin
               w_state_nxt  = S_IFG;
               w_frames_nxt = r_frames + 16'd1;
            end
         end
         S_DRAIN: begin
            if (tx_valid_i && tx_last_i) begin
               w_state_nxt = S_IFG;
            end
         end
         S_IFG: begin
            // The first IFG cycle still shows the last FCS byte, so the
            // IDLE sample cycle completes the idle gap.
            if (r_tick == IFG_LAST) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      w_tick_nxt = (w_state_nxt != r_state) ? 8'd0 : r_tick + 8'd1;
   end

   always_ff @(posedge TXCLK_i) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_g        <= 8'h00;
         r_en       <= 1'b0;
         r_er       <= 1'b0;
         r_cnt      <= 16'd0;
         r_crc      <= 32'd0;
         r_tick     <= 8'd0;
         r_frames   <= 16'd0;
         r_underrun <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_g        <= w_g_nxt;
         r_en       <= w_en_nxt;
         r_er       <= w_er_nxt;
         r_cnt      <= w_cnt_nxt;
         r_crc      <= w_crc_nxt;
         r_tick     <= w_tick_nxt;
         r_frames   <= w_frames_nxt;
         r_underrun <= w_underrun_nxt;
      end
   end

   always_ff @(posedge TXCLK_i) begin
      if (!reset) begin
         r_pos     <= 4'h0;
         r_ctl_pos <= 1'b0;
         r_hi_hold <= 4'h0;
         r_x_hold  <= 1'b0;
      end else begin
         r_pos     <= r_g[3:0];
         r_ctl_pos <= r_en;
         r_hi_hold <= r_g[7:4];
         r_x_hold  <= r_en ^ r_er;
      end
   end

   always_ff @(negedge TXCLK_i) begin
      if (!reset) begin
         r_neg     <= 4'h0;
         r_ctl_neg <= 1'b0;
      end else begin
         r_neg     <= r_hi_hold;
         r_ctl_neg <= r_x_hold;
      end
   end

   assign RGMII_TXD_o   = TXCLK_i ? r_pos : r_neg;
   assign RGMII_TXCTL_o = TXCLK_i ? r_ctl_pos : r_ctl_neg;

endmodule

// File: tb/tb_gmii_to_rgmii_tx.sv
// tb_gmii_to_rgmii_tx: self-checking bench for gmii_to_rgmii_tx.
// Instance 0 has padding disabled, instance 1 uses the defaults.
module tb_gmii_to_rgmii_tx;

   localparam int PL  = 7;
   localparam int IFG = 12;

   typedef struct {
      logic [3:0]  lo;
      logic [3:0]  hi;
      logic        c0;
      logic        c1;
      logic        und;
      logic        rdy;
      logic        busy;
      logic [15:0] fc;
   } rec_t;

   typedef struct {
      logic [7:0] d;
      logic       er;
   } exp_t;

   typedef struct {
      int inst;
      int len;
      int seed;
   } vec_t;

   logic        clk = 1'b0;
   logic        rstn [2];
   logic [7:0]  dat  [2];
   logic        vld  [2];
   logic        lst  [2];
   logic        rdy  [2];
   logic        txc  [2];
   logic [3:0]  txd  [2];
   logic        ctl  [2];
   logic        busy [2];
   logic        und  [2];
   logic [15:0] fc   [2];

   rec_t       obs0 [$];
   rec_t       obs1 [$];
   exp_t       exp_q [$];
   logic [7:0] pay [$];
   logic       lastf [$];
   int         spans [$];
   int         gaps [$];
   int         und_cnt;
   logic [15:0] last_fc;
   logic [9:0] sfd_pins;
   int         efc [2];
   int         checks = 0;
   int         errors = 0;

   always #4 clk = ~clk;

   gmii_to_rgmii_tx #(
      .PREAMBLE_LEN(7),
      .MIN_FRAME(0),
      .IFG_BYTES(12)
   ) u_nopad (
      .TXCLK_i(clk),
      .reset(rstn[0]),
      .tx_data_i(dat[0]),
      .tx_valid_i(vld[0]),
      .tx_last_i(lst[0]),
      .tx_ready_o(rdy[0]),
      .RGMII_TXC_o(txc[0]),
      .RGMII_TXD_o(txd[0]),
      .RGMII_TXCTL_o(ctl[0]),
      .busy_o(busy[0]),
      .underrun_o(und[0]),
      .frame_cnt_o(fc[0])
   );

   gmii_to_rgmii_tx u_dut (
      .TXCLK_i(clk),
      .reset(rstn[1]),
      .tx_data_i(dat[1]),
      .tx_valid_i(vld[1]),
      .tx_last_i(lst[1]),
      .tx_ready_o(rdy[1]),
      .RGMII_TXC_o(txc[1]),
      .RGMII_TXD_o(txd[1]),
      .RGMII_TXCTL_o(ctl[1]),
      .busy_o(busy[1]),
      .underrun_o(und[1]),
      .frame_cnt_o(fc[1])
   );

   initial begin : mon
      rec_t a;
      rec_t b;
      forever begin
         @(posedge clk);
         #2;
         a.lo = txd[0]; a.c0 = ctl[0]; a.und = und[0];
         a.rdy = rdy[0]; a.busy = busy[0]; a.fc = fc[0];
         b.lo = txd[1]; b.c0 = ctl[1]; b.und = und[1];
         b.rdy = rdy[1]; b.busy = busy[1]; b.fc = fc[1];
         @(negedge clk);
         #2;
         a.hi = txd[0]; a.c1 = ctl[0];
         b.hi = txd[1]; b.c1 = ctl[1];
         obs0.push_back(a);
         obs1.push_back(b);
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   function automatic logic [31:0] crc_step(input logic [31:0] c,
                                            input logic [7:0] b);
      logic [31:0] v;
      logic        fb;
      v = c;
      for (int i = 0; i < 8; i++) begin
         fb = v[0] ^ b[i];
         v  = {1'b0, v[31:1]};
         if (fb) v = v ^ 32'hEDB88320;
      end
      return v;
   endfunction

   task automatic push_exp(input logic [7:0] d, input logic er);
      exp_t e;
      e.d  = d;
      e.er = er;
      exp_q.push_back(e);
   endtask

   task automatic push_hdr();
      for (int i = 0; i < PL; i++) push_exp(8'h55, 1'b0);
      push_exp(8'hD5, 1'b0);
   endtask

   // Appends a frame to the drive queue; optionally its expected pin bytes.
   task automatic add_frame(input int inst, input int len, input int seed,
                            input bit want);
      int          mn;
      int          base;
      int          tot;
      logic [31:0] c;
      logic [7:0]  b;
      mn   = (inst == 0) ? 0 : 60;
      base = pay.size();
      for (int j = 0; j < len; j++) begin
         pay.push_back(8'((seed + j * 37) & 255));
         lastf.push_back(j == len - 1);
      end
      if (want) begin
         push_hdr();
         tot = (len > mn) ? len : mn;
         c   = 32'hFFFF_FFFF;
         for (int j = 0; j < tot; j++) begin
            b = (j < len) ? pay[base + j] : 8'h00;
            push_exp(b, 1'b0);
            c = crc_step(c, b);
         end
         c = ~c;
         push_exp(c[7:0], 1'b0);
         push_exp(c[15:8], 1'b0);
         push_exp(c[23:16], 1'b0);
         push_exp(c[31:24], 1'b0);
      end
   endtask

   task automatic send(input int inst, input int bubble_at,
                       output int sent);
      int   i;
      int   guard;
      bit   bub;
      logic acc;
      i = 0; guard = 0; bub = 0;
      while (i < pay.size() && guard < 4000) begin
         @(negedge clk);
         guard++;
         if (i == bubble_at && !bub) begin
            vld[inst] = 1'b0;
            bub = 1;
            @(posedge clk);
            continue;
         end
         vld[inst] = 1'b1;
         dat[inst] = pay[i];
         lst[inst] = lastf[i];
         #1 acc = rdy[inst];
         @(posedge clk);
         if (acc) i++;
      end
      @(negedge clk);
      vld[inst] = 1'b0;
      lst[inst] = 1'b0;
      sent = i;
   endtask

   task automatic wait_idle(input int inst, input string tag);
      int g;
      g = 0;
      while (busy[inst] && g < 4000) begin
         @(posedge clk);
         #1;
         g++;
      end
      chk({tag, " idle_timeout"}, 32'(busy[inst]), 0);
      repeat (4) @(posedge clk);
   endtask

   task automatic analyze(input int inst, input int mark, input string tag);
      rec_t       q [$];
      int         run;
      int         gap;
      bit         bad;
      exp_t       e;
      logic [7:0] d;
      logic       er;
      if (inst == 0) q = obs0;
      else q = obs1;
      spans.delete();
      gaps.delete();
      und_cnt = 0; run = 0; gap = 0; bad = 0;
      sfd_pins = '0;
      for (int k = mark; k < q.size(); k++) begin
         if (q[k].und) und_cnt++;
         last_fc = q[k].fc;
         if (q[k].c0) begin
            if (run == 0 && spans.size() > 0) gaps.push_back(gap);
            if (spans.size() == 0 && run == PL)
               sfd_pins = {q[k].lo, q[k].hi, q[k].c0, q[k].c1};
            run++;
            d  = {q[k].hi, q[k].lo};
            er = q[k].c0 ^ q[k].c1;
            if (!bad) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  bad = 1;
                  $display("FAIL %s extra: byte %02h with none expected",
                           tag, d);
               end else begin
                  e = exp_q.pop_front();
                  if (d !== e.d || er !== e.er) begin
                     errors++;
                     bad = 1;
                     $display("FAIL %s byte: got %02h er=%0d expected %02h er=%0d",
                              tag, d, er, e.d, e.er);
                  end
               end
            end
         end else begin
            if (run > 0) begin
               spans.push_back(run);
               run = 0;
               gap = 0;
            end
            gap++;
         end
      end
      if (run > 0) spans.push_back(run);
      chk({tag, " leftover"}, 32'(exp_q.size()), 0);
      exp_q.delete();
   endtask

   task automatic run_frame(input int inst, input int len, input int seed,
                            input string tag);
      int mark;
      int sent;
      int mn;
      pay.delete();
      lastf.delete();
      add_frame(inst, len, seed, 1);
      mark = (inst == 0) ? obs0.size() : obs1.size();
      send(inst, -1, sent);
      wait_idle(inst, tag);
      analyze(inst, mark, tag);
      efc[inst]++;
      mn = (inst == 0) ? 0 : 60;
      chk({tag, " runs"}, 32'(spans.size()), 1);
      if (spans.size() > 0)
         chk({tag, " en_span"}, 32'(spans[0]),
             32'(PL + 1 + ((len > mn) ? len : mn) + 4));
      chk({tag, " frame_cnt"}, 32'(last_fc), 32'(efc[inst]));
      chk({tag, " no_underrun"}, 32'(und_cnt), 0);
   endtask

   initial begin : main
      vec_t vecs [7];
      int   mark;
      int   sent;

      vecs[0] = '{inst: 1, len: 1,   seed: 'hAA};
      vecs[1] = '{inst: 1, len: 59,  seed: 3};
      vecs[2] = '{inst: 1, len: 60,  seed: 7};
      vecs[3] = '{inst: 1, len: 61,  seed: 11};
      vecs[4] = '{inst: 1, len: 100, seed: 23};
      vecs[5] = '{inst: 0, len: 1,   seed: 5};
      vecs[6] = '{inst: 0, len: 64,  seed: 9};

      for (int i = 0; i < 2; i++) begin
         rstn[i] = 1'b0; vld[i] = 1'b0; lst[i] = 1'b0; dat[i] = 8'h00;
         efc[i] = 0;
      end
      repeat (4) @(posedge clk);
      #1;
      rstn[0] = 1'b1;
      rstn[1] = 1'b1;

      // reset / idle state
      @(posedge clk);
      #2;
      chk("rst txd_hi", 32'(txd[1]), 0);
      chk("rst txctl_hi", 32'(ctl[1]), 0);
      chk("rst ready", 32'(rdy[1]), 0);
      chk("rst busy", 32'(busy[1]), 0);
      chk("rst underrun", 32'(und[1]), 0);
      chk("rst frame_cnt", 32'(fc[1]), 0);
      chk("rst nopad txd", 32'(txd[0]), 0);
      @(negedge clk);
      #2;
      chk("rst txd_lo", 32'(txd[1]), 0);
      chk("rst txctl_lo", 32'(ctl[1]), 0);

      // "123456789" with padding disabled, FCS from the known check value
      pay.delete();
      lastf.delete();
      for (int j = 0; j < 9; j++) begin
         pay.push_back(8'(8'h31 + j));
         lastf.push_back(j == 8);
      end
      push_hdr();
      for (int j = 0; j < 9; j++) push_exp(8'(8'h31 + j), 1'b0);
      push_exp(8'h26, 1'b0);
      push_exp(8'h39, 1'b0);
      push_exp(8'hF4, 1'b0);
      push_exp(8'hCB, 1'b0);
      mark = obs0.size();
      send(0, -1, sent);
      wait_idle(0, "crc_check");
      analyze(0, mark, "crc_check");
      efc[0]++;
      chk("crc_check en_span", 32'(spans.size() > 0 ? spans[0] : 0), 21);
      chk("crc_check frame_cnt", 32'(last_fc), 32'(efc[0]));
      chk("sfd pins", 32'(sfd_pins), 32'({4'h5, 4'hD, 1'b1, 1'b1}));

      // table of single frames
      for (int v = 0; v < 7; v++) begin
         run_frame(vecs[v].inst, vecs[v].len, vecs[v].seed,
                   $sformatf("vec%0d", v));
      end

      // two frames queued with no gap in tx_valid_i
      pay.delete();
      lastf.delete();
      add_frame(1, 64, 1, 1);
      add_frame(1, 10, 2, 1);
      mark = obs1.size();
      send(1, -1, sent);
      wait_idle(1, "b2b");
      analyze(1, mark, "b2b");
      efc[1] += 2;
      chk("b2b runs", 32'(spans.size()), 2);
      chk("b2b span0", 32'(spans.size() > 0 ? spans[0] : 0), 76);
      chk("b2b span1", 32'(spans.size() > 1 ? spans[1] : 0), 72);
      chk("b2b ifg", 32'(gaps.size() > 0 ? gaps[0] : 0), IFG);
      chk("b2b frame_cnt", 32'(last_fc), 32'(efc[1]));

      // underrun after the 5th of 20 bytes
      pay.delete();
      lastf.delete();
      add_frame(1, 20, 5, 0);
      push_hdr();
      for (int j = 0; j < 5; j++) push_exp(pay[j], 1'b0);
      push_exp(8'h00, 1'b1);
      mark = obs1.size();
      send(1, 5, sent);
      wait_idle(1, "underrun");
      analyze(1, mark, "underrun");
      chk("underrun drained", 32'(sent), 20);
      chk("underrun pulses", 32'(und_cnt), 1);
      chk("underrun en_span", 32'(spans.size() > 0 ? spans[0] : 0), 14);
      chk("underrun frame_cnt", 32'(last_fc), 32'(efc[1]));

      // reset pulse in the middle of the payload
      @(negedge clk);
      vld[1] = 1'b1;
      dat[1] = 8'h3C;
      lst[1] = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      rstn[1] = 1'b0;
      vld[1]  = 1'b0;
      @(posedge clk);
      #1;
      rstn[1] = 1'b1;
      #1;
      chk("midrst txd_hi", 32'(txd[1]), 0);
      chk("midrst txctl_hi", 32'(ctl[1]), 0);
      chk("midrst ready", 32'(rdy[1]), 0);
      chk("midrst busy", 32'(busy[1]), 0);
      chk("midrst underrun", 32'(und[1]), 0);
      chk("midrst frame_cnt", 32'(fc[1]), 0);
      @(negedge clk);
      #2;
      chk("midrst txd_lo", 32'(txd[1]), 0);
      chk("midrst txctl_lo", 32'(ctl[1]), 0);
      efc[1] = 0;
      repeat (2) @(posedge clk);
      run_frame(1, 30, 77, "after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
